fetch_stage: RTL

//  IF stage of the 5-stage MIPS pipeline: holds the PC, issues instruction-memory requests over a req/ack

---
 rtl/fetch_stage.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, req/ack instruction fetch,
// redirect tracking across outstanding requests, and the IF/ID register.
// Optional feature macro: IF_PERF_CNT_EN adds saturating fetch/discard counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef IF_PERF_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcS,
  input  logic        jumpS,
  input  logic        FlushS,
  input  logic [31:0] branchTarget,
  input  logic [31:0] jumpTarget,
  input  logic        stallD,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemRdata,
  output logic [31:0] instrD,
  output logic [31:0] pcPlus4D,
  output logic        validD
`ifdef IF_PERF_CNT_EN
  , output logic [CNT_W-1:0] fetchCnt
  , output logic [CNT_W-1:0] discardCnt
`endif
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {S_REQ, S_HOLD} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] hold_buf;
  logic            redir_pend;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] load_instr;
  logic            load_if;
  logic            discard;

  // Request is a decode of the state register, forced low while in reset
  assign imemReq  = (state == S_REQ) && !rst;
  assign imemAddr = pc;

  // Redirect selection and per-cycle load/discard decisions
  always_comb begin
    redirect   = PCSrcS | jumpS;
    target     = PCSrcS ? branchTarget : jumpTarget;
    pc_plus4   = pc + XLEN'(4);
    load_instr = imemRdata;
    load_if    = 1'b0;
    discard    = 1'b0;
    case (state)
      S_REQ: begin
        if (imemAck) begin
          if (redirect || redir_pend) discard = 1'b1;
          else if (!stallD)           load_if = 1'b1;
        end
      end
      S_HOLD: begin
        load_instr = hold_buf;
        if (redirect)     discard = 1'b1;
        else if (!stallD) load_if = 1'b1;
      end
    endcase
  end

  // Fetch FSM: PC, pending redirect and stall buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      redir_pend <= 1'b0;
      redir_tgt  <= '0;
      hold_buf   <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (imemAck) begin
            if (discard) begin
              // A redirect seen this cycle is newer than any pending one
              pc         <= redirect ? target : redir_tgt;
              redir_pend <= 1'b0;
            end else if (load_if) begin
              pc <= pc_plus4;
            end else begin
              hold_buf <= imemRdata;
              state    <= S_HOLD;
            end
          end else if (redirect) begin
            redir_pend <= 1'b1;
            redir_tgt  <= target;
          end
        end
        S_HOLD: begin
          if (discard) begin
            pc    <= target;
            state <= S_REQ;
          end else if (load_if) begin
            pc    <= pc_plus4;
            state <= S_REQ;
          end
        end
      endcase
    end
  end

  // IF/ID register: flush > stall hold > load > bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      instrD   <= '0;
      pcPlus4D <= '0;
      validD   <= 1'b0;
    end else if (FlushS) begin
      instrD <= '0;
      validD <= 1'b0;
    end else if (stallD) begin
      instrD <= instrD;
    end else if (load_if) begin
      instrD   <= load_instr;
      pcPlus4D <= pc_plus4;
      validD   <= 1'b1;
    end else begin
      instrD <= '0;
      validD <= 1'b0;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      fetchCnt   <= '0;
      discardCnt <= '0;
    end else begin
      if (load_if && !FlushS && (fetchCnt != '1)) fetchCnt <= fetchCnt + CNT_W'(1);
      if (discard && (discardCnt != '1))          discardCnt <= discardCnt + CNT_W'(1);
    end
  end
`endif

endmodule
